sha_input_loader: RTL and testbench

Parametrised, registered input router for the SHA-256 core. It accepts a stream of address-tagged data words from the host side over a valid/ready handshake. Address 0 carries message-schedule words, which go into a one-entry output register with their own valid/ready handshake and a word index; addresses 1..N_VARS load a bank of working-variable/hash registers. It sits between the host interface and the compression core, and adds buffering, block framing, load tracking and address checking.

---
 rtl/sha_input_loader.sv | 137 +++++++++++++
 tb/tb_sha_input_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha_input_loader.sv
// Address-tagged input router for the SHA-256 core: message words go to a one-entry handshake buffer, other addresses load the variable bank.
// Optional feature: define INPUT_MUX_BSWAP_EN to byte-reverse message words before they are registered.
module sha_input_loader #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 4,
   parameter int N_VARS  = 8,
   parameter int N_WORDS = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ADDR_W-1:0]            in_addr,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         w_valid,
   input  logic                         w_ready,
   output logic [DATA_W-1:0]            w_data,
   output logic [$clog2(N_WORDS)-1:0]   w_idx,
   output logic                         block_done,
   output logic [N_VARS*DATA_W-1:0]     out_var,
   output logic [N_VARS-1:0]            var_loaded,
   output logic                         addr_err
);

   localparam int IDX_W = $clog2(N_WORDS);
   localparam logic [ADDR_W-1:0] CLR_ADDR = {ADDR_W{1'b1}};

   logic                     w_valid_q, w_valid_d;
   logic [DATA_W-1:0]        w_data_q, w_data_d;
   logic [IDX_W-1:0]         w_idx_q, w_idx_d;
   logic [IDX_W-1:0]         cnt_q, cnt_d;
   logic                     block_done_q, block_done_d;
   logic [DATA_W-1:0]        var_q [N_VARS];
   logic [DATA_W-1:0]        var_d [N_VARS];
   logic [N_VARS-1:0]        var_loaded_q, var_loaded_d;
   logic                     addr_err_q, addr_err_d;

   logic                     accept, out_xfer;
   logic                     is_msg, is_var, is_clr, is_bad;
   logic [IDX_W-1:0]         cnt_inc;
   logic [DATA_W-1:0]        msg_word;

`ifdef INPUT_MUX_BSWAP_EN
   function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] x);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int b = 0; b < DATA_W/8; b++) begin
         r[b*8 +: 8] = x[(DATA_W/8-1-b)*8 +: 8];
      end
      return r;
   endfunction
   assign msg_word = bswap(in_data);
`else
   assign msg_word = in_data;
`endif

   assign in_ready = !w_valid_q || w_ready;
   assign accept   = in_valid && in_ready;
   assign out_xfer = w_valid_q && w_ready;

   assign is_msg = accept && (in_addr == '0);
   assign is_clr = accept && (in_addr == CLR_ADDR);
   assign is_var = accept && (in_addr != '0) && (in_addr <= ADDR_W'(N_VARS));
   assign is_bad = accept && !is_msg && !is_clr && !is_var;

   assign cnt_inc = (cnt_q == IDX_W'(N_WORDS-1)) ? '0 : cnt_q + IDX_W'(1);

   always_comb begin
      w_valid_d    = w_valid_q;
      w_data_d     = w_data_q;
      w_idx_d      = w_idx_q;
      cnt_d        = cnt_q;
      block_done_d = out_xfer && (w_idx_q == IDX_W'(N_WORDS-1));
      var_d        = var_q;
      var_loaded_d = var_loaded_q;
      addr_err_d   = addr_err_q;

      if (out_xfer) begin
         cnt_d     = cnt_inc;
         w_valid_d = 1'b0;
      end
      // A word loaded in the same cycle the previous one leaves is tagged with the advanced count
      if (is_msg) begin
         w_valid_d = 1'b1;
         w_data_d  = msg_word;
         w_idx_d   = out_xfer ? cnt_inc : cnt_q;
      end
      for (int k = 0; k < N_VARS; k++) begin
         if (is_var && (in_addr == ADDR_W'(k+1))) begin
            var_d[k]        = in_data;
            var_loaded_d[k] = 1'b1;
         end
      end
      if (is_bad) begin
         addr_err_d = 1'b1;
      end
      if (is_clr) begin
         cnt_d        = '0;
         var_loaded_d = '0;
         addr_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_valid_q    <= 1'b0;
         w_data_q     <= '0;
         w_idx_q      <= '0;
         cnt_q        <= '0;
         block_done_q <= 1'b0;
         for (int k = 0; k < N_VARS; k++) var_q[k] <= '0;
         var_loaded_q <= '0;
         addr_err_q   <= 1'b0;
      end else begin
         w_valid_q    <= w_valid_d;
         w_data_q     <= w_data_d;
         w_idx_q      <= w_idx_d;
         cnt_q        <= cnt_d;
         block_done_q <= block_done_d;
         var_q        <= var_d;
         var_loaded_q <= var_loaded_d;
         addr_err_q   <= addr_err_d;
      end
   end

   assign w_valid    = w_valid_q;
   assign w_data     = w_data_q;
   assign w_idx      = w_idx_q;
   assign block_done = block_done_q;
   assign var_loaded = var_loaded_q;
   assign addr_err   = addr_err_q;

   for (genvar g = 0; g < N_VARS; g++) begin : g_pack
      assign out_var[g*DATA_W +: DATA_W] = var_q[g];
   end

endmodule

// File: tb/tb_sha_input_loader.sv
// Directed self-checking bench for sha_input_loader (default parameters).
module tb_sha_input_loader;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_addr;
   logic [31:0]   in_data;
   logic          w_valid;
   logic          w_ready;
   logic [31:0]   w_data;
   logic [3:0]    w_idx;
   logic          block_done;
   logic [255:0]  out_var;
   logic [7:0]    var_loaded;
   logic          addr_err;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] iv [8] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                           32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};

   sha_input_loader dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx),
      .block_done(block_done), .out_var(out_var), .var_loaded(var_loaded), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   // Expected message-path word for a given input word
   function automatic logic [31:0] exp_w(input logic [31:0] x);
`ifdef INPUT_MUX_BSWAP_EN
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
      return x;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; w_ready = 1'b0;
      #3;
      compared++;
      if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
      compared++;
      if ({w_valid, block_done, addr_err} !== 3'b000 || w_data !== 32'h0 || w_idx !== 4'h0) begin
         mismatched++; $display("[TB] FAIL reset_msg got v=%b d=%h i=%0d bd=%b err=%b want zeros", w_valid, w_data, w_idx, block_done, addr_err);
      end
      compared++;
      if (out_var !== 256'h0 || var_loaded !== 8'h00) begin
         mismatched++; $display("[TB] FAIL reset_vars got loaded=%h want 00 and zero bank", var_loaded);
      end
      #9 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_stream();
      w_ready = 1'b1; in_valid = 1'b1; in_addr = 4'h0;
      for (int i = 0; i < 16; i++) begin
         in_data = 32'(i);
         tick();
         compared++;
         if (w_valid !== 1'b1 || w_data !== exp_w(32'(i)) || w_idx !== 4'(i) || block_done !== 1'b0) begin
            mismatched++; $display("[TB] FAIL stream_word%0d got v=%b d=%h i=%0d bd=%b want 1 %h %0d 0", i, w_valid, w_data, w_idx, block_done, exp_w(32'(i)), i);
         end
      end
      in_valid = 1'b0;
      tick();
      compared++;
      if (block_done !== 1'b1 || w_valid !== 1'b0) begin
         mismatched++; $display("[TB] FAIL stream_block_done got bd=%b v=%b want 1 0", block_done, w_valid);
      end
      tick();
      compared++;
      if (block_done !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_done_pulse got %b want 0", block_done); end
   endtask

   task automatic test_backpressure();
      w_ready = 1'b0; in_valid = 1'b1; in_addr = 4'h0; in_data = 32'hDEADBEEF;
      tick();
      compared++;
      if (w_valid !== 1'b1 || w_data !== exp_w(32'hDEADBEEF) || w_idx !== 4'h0) begin
         mismatched++; $display("[TB] FAIL bp_load got v=%b d=%h i=%0d want 1 %h 0", w_valid, w_data, w_idx, exp_w(32'hDEADBEEF));
      end
      in_addr = 4'h1; in_data = 32'hCAFEF00D;
      #1;
      compared++;
      if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_in_ready got %b want 0", in_ready); end
      repeat (3) tick();
      compared++;
      if (w_data !== exp_w(32'hDEADBEEF) || w_valid !== 1'b1 || out_var[31:0] !== 32'h0 || var_loaded !== 8'h00) begin
         mismatched++; $display("[TB] FAIL bp_hold got d=%h v=%b var0=%h ld=%h want %h 1 0 00", w_data, w_valid, out_var[31:0], var_loaded, exp_w(32'hDEADBEEF));
      end
      w_ready = 1'b1;
      #1;
      compared++;
      if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release_ready got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      compared++;
      if (w_valid !== 1'b0 || out_var[31:0] !== 32'hCAFEF00D || var_loaded !== 8'h01) begin
         mismatched++; $display("[TB] FAIL bp_var_after got v=%b var0=%h ld=%h want 0 cafef00d 01", w_valid, out_var[31:0], var_loaded);
      end
   endtask

   task automatic test_var_load();
      w_ready = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_addr = 4'(k + 1); in_data = iv[k];
         tick();
         compared++;
         if (out_var[k*32 +: 32] !== iv[k] || w_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL var_load%0d got %h v=%b want %h 0", k, out_var[k*32 +: 32], w_valid, iv[k]);
         end
      end
      in_valid = 1'b0;
      compared++;
      if (var_loaded !== 8'hFF) begin mismatched++; $display("[TB] FAIL var_loaded_all got %h want ff", var_loaded); end
   endtask

   task automatic test_illegal_and_clear();
      logic [255:0] snap;
      snap = {iv[7], iv[6], iv[5], iv[4], iv[3], iv[2], iv[1], iv[0]};
      in_valid = 1'b1; in_addr = 4'h9; in_data = 32'h12345678;
      tick();
      compared++;
      if (addr_err !== 1'b1 || out_var !== snap || var_loaded !== 8'hFF) begin
         mismatched++; $display("[TB] FAIL illegal_addr got err=%b ld=%h bank_ok=%b want 1 ff 1", addr_err, var_loaded, out_var === snap);
      end
      in_addr = 4'hE;
      tick();
      compared++;
      if (addr_err !== 1'b1 || out_var !== snap) begin
         mismatched++; $display("[TB] FAIL illegal_top got err=%b bank_ok=%b want 1 1", addr_err, out_var === snap);
      end
      in_addr = 4'hF;
      tick();
      in_valid = 1'b0;
      compared++;
      if (addr_err !== 1'b0 || var_loaded !== 8'h00 || out_var !== snap) begin
         mismatched++; $display("[TB] FAIL clear_cmd got err=%b ld=%h bank_ok=%b want 0 00 1", addr_err, var_loaded, out_var === snap);
      end
   endtask

   task automatic test_clear_mid_block();
      w_ready = 1'b1; in_valid = 1'b1; in_addr = 4'h0;
      for (int i = 0; i < 8; i++) begin
         in_data = 32'h100 + 32'(i);
         tick();
         compared++;
         if (w_idx !== 4'(i) || w_data !== exp_w(32'h100 + 32'(i))) begin
            mismatched++; $display("[TB] FAIL clr_pre%0d got i=%0d d=%h want %0d %h", i, w_idx, w_data, i, exp_w(32'h100 + 32'(i)));
         end
      end
      in_addr = 4'hF;
      tick();
      compared++;
      if (w_valid !== 1'b0 || block_done !== 1'b0) begin
         mismatched++; $display("[TB] FAIL clr_consume got v=%b bd=%b want 0 0", w_valid, block_done);
      end
      in_addr = 4'h0; in_data = 32'h200;
      tick();
      in_valid = 1'b0;
      compared++;
      if (w_valid !== 1'b1 || w_idx !== 4'h0 || w_data !== exp_w(32'h200)) begin
         mismatched++; $display("[TB] FAIL clr_next_idx got v=%b i=%0d d=%h want 1 0 %h", w_valid, w_idx, w_data, exp_w(32'h200));
      end
      tick();
   endtask

   task automatic test_bswap();
      w_ready = 1'b1; in_valid = 1'b1; in_addr = 4'h0; in_data = 32'h11223344;
      tick();
      compared++;
`ifdef INPUT_MUX_BSWAP_EN
      if (w_data !== 32'h44332211) begin mismatched++; $display("[TB] FAIL bswap_msg got %h want 44332211", w_data); end
`else
      if (w_data !== 32'h11223344) begin mismatched++; $display("[TB] FAIL bswap_msg got %h want 11223344", w_data); end
`endif
      in_addr = 4'h2;
      tick();
      in_valid = 1'b0;
      compared++;
      if (out_var[63:32] !== 32'h11223344) begin mismatched++; $display("[TB] FAIL bswap_var got %h want 11223344", out_var[63:32]); end
   endtask

   task automatic test_reset_mid();
      w_ready = 1'b0; in_valid = 1'b1; in_addr = 4'h0; in_data = 32'hABCD;
      tick();
      in_valid = 1'b0;
      compared++;
      if (w_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_pre got %b want 1", w_valid); end
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if (w_valid !== 1'b0 || w_data !== 32'h0 || in_ready !== 1'b1 || out_var !== 256'h0) begin
         mismatched++; $display("[TB] FAIL rstmid_async got v=%b d=%h rdy=%b want 0 0 1", w_valid, w_data, in_ready);
      end
      rst_n = 1'b1;
      tick();
      compared++;
      if (w_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_after got %b want 0", w_valid); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_var_load();
      test_illegal_and_clear();
      test_clear_mid_block();
      test_bswap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
